// File: rtl/mem_access_pkg.sv
// Shared types and constants for the memory-access stage.
// Holds the size encodings, FSM states and counter width.
package mem_access_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_ILL  = 2'b11;

  // Wide enough for MEM_LATENCY up to 7.
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

endpackage

// File: rtl/data_mem_bank.sv
// Byte-enabled word array: one registered read/write port,
// one registered debug read port (read-before-write).
// Ports: i_clk, i_rst (async low), i_we/i_be/i_wdata write,
//   i_re read strobe, i_idx word index, o_rdata read word,
//   i_dbg_idx/o_dbg_data debug read (every clock).
module data_mem_bank #(
  parameter  int NBITS       = 32,
  parameter  int DEPTH_WORDS = 256,
  localparam int AW          = $clog2(DEPTH_WORDS),
  localparam int NB          = NBITS / 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_we,
  input  logic [NB-1:0]    i_be,
  input  logic             i_re,
  input  logic [AW-1:0]    i_idx,
  input  logic [NBITS-1:0] i_wdata,
  output logic [NBITS-1:0] o_rdata,
  input  logic [AW-1:0]    i_dbg_idx,
  output logic [NBITS-1:0] o_dbg_data
);

  logic [NBITS-1:0] mem_q [DEPTH_WORDS];
  logic [NBITS-1:0] rdata_q;
  logic [NBITS-1:0] dbg_q;

  // Contents are deliberately not reset.
  always_ff @(posedge i_clk) begin
    for (int b = 0; b < NB; b++) begin
      if (i_we && i_be[b]) begin
        mem_q[i_idx][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      rdata_q <= '0;
      dbg_q   <= '0;
    end else begin
      dbg_q <= mem_q[i_dbg_idx];
      if (i_re) begin
        rdata_q <= mem_q[i_idx];
      end
    end
  end

  assign o_rdata    = rdata_q;
  assign o_dbg_data = dbg_q;

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access stage: latency-modelled load/store with
// lane steering, sign/zero extension and fault detection.
// Ports: i_clk, i_rst (async low), i_step advance enable,
//   i_req/i_wr_en/i_size/i_unsigned/i_addr/i_wdata request,
//   i_dbg_addr debug address; o_rdata load result,
//   o_dbg_data debug word, o_busy, o_done, o_fault.
// Macro MEM_ACCESS_ALIGN_CHECK_EN: misaligned half/word
//   accesses fault; otherwise low address bits are dropped.
module mem_access_stage
  import mem_access_pkg::*;
#(
  parameter int NBITS       = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int MEM_LATENCY = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_step,
  input  logic             i_req,
  input  logic             i_wr_en,
  input  logic [1:0]       i_size,
  input  logic             i_unsigned,
  input  logic [NBITS-1:0] i_addr,
  input  logic [NBITS-1:0] i_wdata,
  input  logic [NBITS-1:0] i_dbg_addr,
  output logic [NBITS-1:0] o_rdata,
  output logic [NBITS-1:0] o_dbg_data,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_fault
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int NB = NBITS / 8;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;
  logic             fin;

  logic [1:0]       req_lane;
  logic             misal;
  logic             oor;
  logic             req_flt;

  logic [AW-1:0]    op_idx_q;
  logic [1:0]       op_lane_q;
  logic [1:0]       op_size_q;
  logic             op_uns_q;
  logic             op_wr_q;
  logic             op_flt_q;
  logic [NBITS-1:0] op_wdata_q;

  logic             done_q;
  logic             fault_q;
  logic             res_ld_q;
  logic [1:0]       res_lane_q;
  logic [1:0]       res_size_q;
  logic             res_uns_q;

  logic             mem_we;
  logic             mem_re;
  logic [NB-1:0]    wr_be;
  logic [NBITS-1:0] wr_data;
  logic [NBITS-1:0] rd_raw;
  logic [NBITS-1:0] lane_word;
  logic [NBITS-1:0] ext;
  logic [AW-1:0]    dbg_idx;
  logic             unused_dbg;

  assign oor = |i_addr[NBITS-1:AW+2];

  always_comb begin
    req_lane = i_addr[1:0];
    misal    = 1'b0;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    unique case (1'b1)
      (i_size == SIZE_HALF): misal = i_addr[0];
      (i_size == SIZE_WORD): misal = |i_addr[1:0];
      default:               misal = 1'b0;
    endcase
`else
    unique case (1'b1)
      (i_size == SIZE_HALF): req_lane = {i_addr[1], 1'b0};
      (i_size == SIZE_WORD): req_lane = 2'b00;
      default:               req_lane = i_addr[1:0];
    endcase
`endif
  end

  assign req_flt = (i_size == SIZE_ILL) | oor | misal;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    fin     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_step && i_req) begin
          accept = 1'b1;
          cnt_d  = CNT_W'(MEM_LATENCY);
          state_d = (MEM_LATENCY == 0) ? ST_ACCESS
                                       : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (i_step) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        if (i_step) begin
          fin     = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      fault_q    <= 1'b0;
      op_idx_q   <= '0;
      op_lane_q  <= '0;
      op_size_q  <= '0;
      op_uns_q   <= 1'b0;
      op_wr_q    <= 1'b0;
      op_flt_q   <= 1'b0;
      op_wdata_q <= '0;
      res_ld_q   <= 1'b0;
      res_lane_q <= '0;
      res_size_q <= '0;
      res_uns_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (i_step) begin
        done_q  <= fin;
        fault_q <= fin & op_flt_q;
      end
      if (accept) begin
        op_idx_q   <= i_addr[AW+1:2];
        op_lane_q  <= req_lane;
        op_size_q  <= i_size;
        op_uns_q   <= i_unsigned;
        op_wr_q    <= i_wr_en;
        op_flt_q   <= req_flt;
        op_wdata_q <= i_wdata;
      end
      // Result shape is kept separately so o_rdata
      // survives the next accept until it completes.
      if (fin) begin
        res_ld_q   <= ~op_flt_q & ~op_wr_q;
        res_lane_q <= op_lane_q;
        res_size_q <= op_size_q;
        res_uns_q  <= op_uns_q;
      end
    end
  end

  assign mem_we  = fin & ~op_flt_q & op_wr_q;
  assign mem_re  = fin & ~op_flt_q & ~op_wr_q;
  assign wr_data = op_wdata_q << {op_lane_q, 3'b000};

  always_comb begin
    unique case (1'b1)
      (op_size_q == SIZE_BYTE): wr_be = NB'(1) << op_lane_q;
      (op_size_q == SIZE_HALF): wr_be = NB'(3) << op_lane_q;
      default:                  wr_be = '1;
    endcase
  end

  assign dbg_idx    = i_dbg_addr[AW+1:2];
  assign unused_dbg = ^{i_dbg_addr[NBITS-1:AW+2],
                        i_dbg_addr[1:0]};

  data_mem_bank #(
    .NBITS      (NBITS),
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_bank (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_we      (mem_we),
    .i_be      (wr_be),
    .i_re      (mem_re),
    .i_idx     (op_idx_q),
    .i_wdata   (wr_data),
    .o_rdata   (rd_raw),
    .i_dbg_idx (dbg_idx),
    .o_dbg_data(o_dbg_data)
  );

  always_comb begin
    lane_word = rd_raw >> {res_lane_q, 3'b000};
    unique case (1'b1)
      (res_size_q == SIZE_BYTE):
        ext = {{(NBITS-8){~res_uns_q & lane_word[7]}},
               lane_word[7:0]};
      (res_size_q == SIZE_HALF):
        ext = {{(NBITS-16){~res_uns_q & lane_word[15]}},
               lane_word[15:0]};
      default: ext = lane_word;
    endcase
  end

  assign o_rdata = res_ld_q ? ext : '0;
  assign o_busy  = (state_q != ST_IDLE);
  assign o_done  = done_q;
  assign o_fault = fault_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage with a byte-array
// reference model, random stepping and directed corners.
module tb_mem_access_stage;
  import mem_access_pkg::*;

  localparam int NBITS = 32;
  localparam int DEPTH = 8;
  localparam int LAT   = 3;

  logic              i_clk = 0;
  logic              i_rst = 0;
  logic              i_step = 0;
  logic              i_req = 0;
  logic              i_wr_en = 0;
  logic [1:0]        i_size = 0;
  logic              i_unsigned = 0;
  logic [NBITS-1:0]  i_addr = 0;
  logic [NBITS-1:0]  i_wdata = 0;
  logic [NBITS-1:0]  i_dbg_addr = 0;
  logic [NBITS-1:0]  o_rdata;
  logic [NBITS-1:0]  o_dbg_data;
  logic              o_busy;
  logic              o_done;
  logic              o_fault;

  always #5 i_clk = ~i_clk;

  mem_access_stage #(
    .NBITS      (NBITS),
    .DEPTH_WORDS(DEPTH),
    .MEM_LATENCY(LAT)
  ) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_step    (i_step),
    .i_req     (i_req),
    .i_wr_en   (i_wr_en),
    .i_size    (i_size),
    .i_unsigned(i_unsigned),
    .i_addr    (i_addr),
    .i_wdata   (i_wdata),
    .i_dbg_addr(i_dbg_addr),
    .o_rdata   (o_rdata),
    .o_dbg_data(o_dbg_data),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_fault   (o_fault)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
  } exp_t;

  exp_t        sb[$];
  byte unsigned mem_m [DEPTH*4];
  int          checks = 0;
  int          failures = 0;
  bit          rnd = 0;
  bit          acc_now = 0;
  bit          pending = 0;
  int          steps = 0;
  bit          busy_ok = 1;
  bit          seen = 0;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  // Reference: plain byte array, access width in bytes.
  function automatic exp_t model(bit wr, logic [1:0] sz,
      bit uns, logic [31:0] a, logic [31:0] wd);
    exp_t e;
    int n;
    int ea;
    longint unsigned v;
    e.rdata = 0;
    e.fault = 0;
    n = (sz == SIZE_BYTE) ? 1 : (sz == SIZE_HALF) ? 2 : 4;
    if (sz == SIZE_ILL || (a >> 2) >= DEPTH) e.fault = 1;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    if (a % n != 0) e.fault = 1;
    ea = int'(a);
`else
    ea = int'(a - a % n);
`endif
    if (e.fault) return e;
    if (wr) begin
      for (int k = 0; k < n; k++) mem_m[ea+k] = wd[8*k +: 8];
    end else begin
      v = 0;
      for (int k = 0; k < n; k++)
        v |= longint'(mem_m[ea+k]) << (8*k);
      if (!uns && v[8*n-1]) v |= ~((64'd1 << (8*n)) - 1);
      e.rdata = v[31:0];
    end
    return e;
  endfunction

  function automatic logic [31:0] mword(int a);
    return {mem_m[a+3], mem_m[a+2], mem_m[a+1], mem_m[a]};
  endfunction

  function automatic bit rstep();
    return rnd ? ($urandom % 4 != 0) : 1'b1;
  endfunction

  task automatic tick(bit st);
    @(negedge i_clk);
    acc_now = 0;
    i_req   = 0;
    i_step  = st;
  endtask

  task automatic do_op(bit wr, logic [1:0] sz, bit uns,
      logic [31:0] a, logic [31:0] wd, bit push);
    bit ok = 0;
    if (push) sb.push_back(model(wr, sz, uns, a, wd));
    for (int t = 0; t < 200; t++) begin
      tick(rstep());
      i_req      = 1;
      i_wr_en    = wr;
      i_size     = sz;
      i_unsigned = uns;
      i_addr     = a;
      i_wdata    = wd;
      if (i_step && !o_busy) begin
        acc_now = 1;
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: addr %h not taken", a);
    end
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 400; t++) begin
      tick(rstep());
      if (!o_busy && sb.size() == 0 && !pending) return;
    end
    checks++;
    failures++;
    $display("FAIL idle_timeout: busy %0b queued %0d",
             o_busy, sb.size());
  endtask

  // Stepped edges since the accept edge.
  always @(posedge i_clk) begin
    if (acc_now) begin
      pending = 1;
      steps   = 0;
      busy_ok = 1;
    end else if (pending && i_step) begin
      steps++;
    end
  end

  always @(negedge i_clk) begin : monitor
    exp_t e;
    if (!o_done) begin
      seen = 0;
      if (pending && !o_busy) busy_ok = 0;
    end else if (!seen) begin
      seen = 1;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: rdata %h", o_rdata);
      end else begin
        e = sb.pop_front();
        chk("rdata", o_rdata, e.rdata);
        chk("fault", {31'd0, o_fault}, {31'd0, e.fault});
      end
      chk("stepped_latency", steps, LAT + 1);
      chk("busy_window", {30'd0, busy_ok, o_busy}, 32'd2);
      pending = 0;
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    bit got;
    logic [31:0] old;

    repeat (3) @(negedge i_clk);
    chk("rst_rdata", o_rdata, 0);
    chk("rst_dbg", o_dbg_data, 0);
    chk("rst_flags", {29'd0, o_busy, o_done, o_fault}, 0);
    i_rst = 1;

    for (int w = 0; w < DEPTH; w++)
      do_op(1, SIZE_WORD, 0, w * 4, $urandom, 1);
    wait_idle();

    do_op(1, SIZE_WORD, 0, 32'h10, 32'hDEADBEEF, 1);
    do_op(0, SIZE_WORD, 0, 32'h10, 0, 1);
    do_op(1, SIZE_BYTE, 0, 32'h13, 32'h80, 1);
    do_op(0, SIZE_BYTE, 0, 32'h13, 0, 1);
    do_op(0, SIZE_BYTE, 1, 32'h13, 0, 1);
    do_op(0, SIZE_WORD, 0, 32'h10, 0, 1);
    do_op(0, SIZE_HALF, 0, 32'h11, 0, 1);
    do_op(0, SIZE_WORD, 0, 32'h10, 0, 1);
    do_op(1, SIZE_WORD, 0, 32'h20, 32'h55AA55AA, 1);
    do_op(1, SIZE_ILL, 0, 32'h04, 32'h11111111, 1);
    do_op(0, SIZE_WORD, 0, 32'h04, 0, 1);
    wait_idle();

    // Two unstepped edges inside WAIT.
    do_op(0, SIZE_WORD, 0, 32'h10, 0, 1);
    got = 0;
    for (n = 1; n <= 12; n++) begin
      tick(!(n == 2 || n == 3));
      if (n == 1) chk("busy_after_accept",
                      {31'd0, o_busy}, 1);
      if (o_done) begin
        got = 1;
        break;
      end
    end
    chk("stall_done_edge", got ? n - 1 : -1, LAT + 3);
    wait_idle();

    // Reset while a legal store is waiting.
    do_op(1, SIZE_WORD, 0, 32'h14, 32'hCAFEF00D, 0);
    tick(1);
    tick(1);
    #2 i_rst = 0;
    #1;
    pending = 0;
    chk("rstw_flags", {29'd0, o_busy, o_done, o_fault}, 0);
    chk("rstw_rdata", o_rdata, 0);
    chk("rstw_dbg", o_dbg_data, 0);
    @(negedge i_clk);
    i_rst = 1;
    do_op(0, SIZE_WORD, 0, 32'h14, 0, 1);
    wait_idle();

    // Debug read colliding with a store.
    i_dbg_addr = 32'h10;
    old = mword(32'h10);
    do_op(1, SIZE_WORD, 0, 32'h10, 32'h12345678, 1);
    got = 0;
    for (int t = 0; t < 20; t++) begin
      tick(1);
      if (o_done) begin
        got = 1;
        break;
      end
    end
    chk("dbg_old", got ? o_dbg_data : 32'hX, old);
    tick(1);
    chk("dbg_new", o_dbg_data, 32'h12345678);
    wait_idle();

    rnd = 1;
    for (int k = 0; k < 300; k++) begin
      logic [1:0]  sz;
      logic [31:0] a;
      sz = ($urandom % 8 == 0) ? SIZE_ILL
                               : 2'($urandom % 3);
      a  = ($urandom % 16 == 0) ? $urandom
           : $urandom_range(0, DEPTH * 4 + 7);
      i_dbg_addr = $urandom;
      do_op($urandom % 2, sz, $urandom % 2, a, $urandom, 1);
    end
    wait_idle();
    rnd = 0;

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
